pooled_multi_queue_fifo: RTL and testbench

- Multi-queue FIFO: one write port routes each word to one of QUEUE_COUNT output streams.
- All queues share a single DEPTH-entry storage pool, managed as per-queue linked lists plus a free bitmap.
- Each queue has RESERVED guaranteed entries; the remainder of the pool is shared.
- Unlike the fixed-storage predecessor, any number of queues may pop in the same cycle. Sits between packet ingress and the per-port output arbiters.

---
 rtl/pooled_multi_queue_fifo_if.sv | 30 +++
 rtl/pooled_multi_queue_fifo.sv | 162 ++++++++++++++++
 tb/tb_pooled_multi_queue_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pooled_multi_queue_fifo_if.sv
// Write/read bundle for the pooled multi-queue FIFO: one shared write port and
// per-queue head/pop streams with occupancy and peak-occupancy status.
interface pooled_multi_queue_fifo_if #(
    parameter int QUEUE_COUNT = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8
);
    localparam int TW = $clog2(QUEUE_COUNT);
    localparam int CW = $clog2(DEPTH + 1);

    logic                              in_valid;
    logic [TW-1:0]                     in_target;
    logic [DATA_WIDTH-1:0]             in_payload;
    logic [QUEUE_COUNT-1:0]            in_ready;
    logic [QUEUE_COUNT-1:0]            out_valid;
    logic [QUEUE_COUNT-1:0]            out_ready;
    logic [QUEUE_COUNT*DATA_WIDTH-1:0] out_payload;
    logic [QUEUE_COUNT*CW-1:0]         occupancy;
    logic [QUEUE_COUNT*CW-1:0]         high_water;

    modport master (
        output in_valid, in_target, in_payload, out_ready,
        input  in_ready, out_valid, out_payload, occupancy, high_water
    );

    modport slave (
        input  in_valid, in_target, in_payload, out_ready,
        output in_ready, out_valid, out_payload, occupancy, high_water
    );
endinterface

// File: rtl/pooled_multi_queue_fifo.sv
// Multi-queue FIFO over one shared entry pool (per-queue linked lists + free bitmap).
// Define POOLED_MULTI_QUEUE_HIGH_WATER_EN to enable per-queue peak-occupancy registers.
module pooled_multi_queue_fifo #(
    parameter int QUEUE_COUNT = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int RESERVED    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pooled_multi_queue_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(QUEUE_COUNT);
    localparam logic [CW-1:0] RES_C   = CW'(RESERVED);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LIMIT_C = CW'(DEPTH - (QUEUE_COUNT - 1) * RESERVED);

    logic [DATA_WIDTH-1:0]  mem        [DEPTH];
    logic [PW-1:0]          next_ptr   [DEPTH];
    logic [DEPTH-1:0]       free_map;
    logic [CW-1:0]          free_count;
    logic [PW-1:0]          head       [QUEUE_COUNT];
    logic [PW-1:0]          tail       [QUEUE_COUNT];
    logic [CW-1:0]          count      [QUEUE_COUNT];
    logic [CW-1:0]          count_next [QUEUE_COUNT];

    logic [QUEUE_COUNT-1:0] ready, valid, pop, push_vec;
    logic [CW-1:0]          short_sum, pop_total;
    logic [PW-1:0]          alloc, tgt_tail;
    logic                   push, tgt_link;

    // Entries still owed to under-reserved queues are not available to others.
    always_comb begin
        short_sum = '0;
        ready     = '0;
        for (int q = 0; q < QUEUE_COUNT; q++)
            if (count[q] < RES_C) short_sum = short_sum + (RES_C - count[q]);
        for (int q = 0; q < QUEUE_COUNT; q++)
            ready[q] = (count[q] < RES_C) || (free_count > short_sum);
    end

    always_comb begin
        alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (free_map[i]) alloc = PW'(i);
    end

    always_comb begin
        valid     = '0;
        pop       = '0;
        push_vec  = '0;
        tgt_tail  = '0;
        tgt_link  = 1'b0;
        pop_total = '0;
        for (int q = 0; q < QUEUE_COUNT; q++) begin
            count_next[q] = count[q];
            valid[q]      = (count[q] != '0);
            pop[q]        = valid[q] && bus.out_ready[q];
            push_vec[q]   = bus.in_valid && (bus.in_target == TW'(q)) && ready[q];
            // Link behind the old tail only if something survives this cycle's pop.
            if (push_vec[q]) begin
                tgt_tail = tail[q];
                tgt_link = ((count[q] - CW'(pop[q])) != '0);
            end
            pop_total     = pop_total + CW'(pop[q]);
            count_next[q] = count[q] + CW'(push_vec[q]) - CW'(pop[q]);
        end
        push = |push_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_map   <= '1;
            free_count <= DEPTH_C;
            for (int q = 0; q < QUEUE_COUNT; q++) begin
                head[q]  <= '0;
                tail[q]  <= '0;
                count[q] <= '0;
            end
        end else begin
            for (int q = 0; q < QUEUE_COUNT; q++) begin
                count[q] <= count_next[q];
                if (push_vec[q]) tail[q] <= alloc;
                if (push_vec[q] && !tgt_link) head[q] <= alloc;
                else if (pop[q])              head[q] <= next_ptr[head[q]];
                if (pop[q]) free_map[head[q]] <= 1'b1;
            end
            if (push) free_map[alloc] <= 1'b0;
            free_count <= free_count - CW'(push) + pop_total;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[alloc] <= bus.in_payload;
            if (tgt_link) next_ptr[tgt_tail] <= alloc;
        end
    end

    always_comb begin
        bus.in_ready    = ready;
        bus.out_valid   = valid;
        bus.out_payload = '0;
        bus.occupancy   = '0;
        for (int q = 0; q < QUEUE_COUNT; q++) begin
            bus.out_payload[q*DATA_WIDTH +: DATA_WIDTH] = mem[head[q]];
            bus.occupancy[q*CW +: CW]                   = count[q];
        end
    end

`ifdef POOLED_MULTI_QUEUE_HIGH_WATER_EN
    logic [CW-1:0] hw [QUEUE_COUNT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int q = 0; q < QUEUE_COUNT; q++) hw[q] <= '0;
        end else begin
            for (int q = 0; q < QUEUE_COUNT; q++)
                if (count_next[q] > hw[q]) hw[q] <= count_next[q];
        end
    end

    always_comb begin
        bus.high_water = '0;
        for (int q = 0; q < QUEUE_COUNT; q++) bus.high_water[q*CW +: CW] = hw[q];
    end
`else
    assign bus.high_water = '0;
`endif

    // Walk every list to build the linked-entry mask used by the pool invariants.
    logic [CW-1:0]    count_sum;
    logic [DEPTH-1:0] linked;
    logic [PW-1:0]    walk_ptr;
    logic             over_limit;

    always_comb begin
        count_sum  = '0;
        linked     = '0;
        walk_ptr   = '0;
        over_limit = 1'b0;
        for (int q = 0; q < QUEUE_COUNT; q++) begin
            count_sum  = count_sum + count[q];
            over_limit = over_limit || (count[q] > LIMIT_C);
            walk_ptr   = head[q];
            for (int k = 0; k < DEPTH; k++) begin
                if (CW'(k) < count[q]) begin
                    linked[walk_ptr] = 1'b1;
                    walk_ptr         = next_ptr[walk_ptr];
                end
            end
        end
    end

    a_conserve: assert property (@(posedge clk) disable iff (!rst_n)
        ((CW+1)'(count_sum) + (CW+1)'(free_count)) == (CW+1)'(DEPTH));
    a_disjoint: assert property (@(posedge clk) disable iff (!rst_n)
        (linked & free_map) == '0);
    a_bound: assert property (@(posedge clk) disable iff (!rst_n) !over_limit);
endmodule

// File: tb/tb_pooled_multi_queue_fifo.sv
// Randomized bench for pooled_multi_queue_fifo against a per-queue list model.
module tb_pooled_multi_queue_fifo;
    localparam int QC    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int RES   = 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int TW    = $clog2(QC);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pooled_multi_queue_fifo_if #(.QUEUE_COUNT(QC), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_if ();

    pooled_multi_queue_fifo #(
        .QUEUE_COUNT(QC), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESERVED(RES)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mdata [QC][DEPTH];
    int            mcnt  [QC];
    int            mhw   [QC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [QC-1:0] model_ready();
        int total     = 0;
        int shortfall = 0;
        int shared;
        logic [QC-1:0] r;
        r = '0;
        for (int q = 0; q < QC; q++) begin
            total += mcnt[q];
            if (mcnt[q] < RES) shortfall += RES - mcnt[q];
        end
        shared = (DEPTH - total) - shortfall;
        for (int q = 0; q < QC; q++) r[q] = (mcnt[q] < RES) || (shared > 0);
        return r;
    endfunction

    function automatic int exp_hw(input int q);
`ifdef POOLED_MULTI_QUEUE_HIGH_WATER_EN
        return mhw[q];
`else
        return 0 * q;
`endif
    endfunction

    task automatic check_all();
        chk("in_ready", 32'(bus_if.in_ready), 32'(model_ready()));
        for (int q = 0; q < QC; q++) begin
            chk("out_valid", 32'(bus_if.out_valid[q]), 32'(mcnt[q] > 0));
            chk("occupancy", 32'(bus_if.occupancy[q*CW +: CW]), mcnt[q]);
            if (mcnt[q] > 0)
                chk("out_payload", 32'(bus_if.out_payload[q*DW +: DW]), 32'(mdata[q][0]));
            chk("high_water", 32'(bus_if.high_water[q*CW +: CW]), exp_hw(q));
        end
    endtask

    task automatic cycle(input logic v, input int tgt, input logic [DW-1:0] pl,
                         input logic [QC-1:0] rdy);
        logic [QC-1:0] mr;
        logic          do_push;
        bus_if.in_valid   = v;
        bus_if.in_target  = TW'(tgt);
        bus_if.in_payload = pl;
        bus_if.out_ready  = rdy;
        mr      = model_ready();
        do_push = 1'b0;
        if (tgt < QC) do_push = v && mr[tgt];
        @(posedge clk);
        for (int q = 0; q < QC; q++) begin
            if (rdy[q] && mcnt[q] > 0) begin
                for (int k = 0; k < DEPTH - 1; k++) mdata[q][k] = mdata[q][k+1];
                mcnt[q]--;
            end
        end
        if (do_push) begin
            mdata[tgt][mcnt[tgt]] = pl;
            mcnt[tgt]++;
        end
        for (int q = 0; q < QC; q++) if (mcnt[q] > mhw[q]) mhw[q] = mcnt[q];
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus_if.in_valid   = 1'b0;
        bus_if.in_target  = '0;
        bus_if.in_payload = '0;
        bus_if.out_ready  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int q = 0; q < QC; q++) begin
            mcnt[q] = 0;
            mhw[q]  = 0;
        end
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'h7);
        check_all();
    endtask

    function automatic int occ_sum();
        int s = 0;
        for (int q = 0; q < QC; q++) s += int'(bus_if.occupancy[q*CW +: CW]);
        return s;
    endfunction

    initial begin
        do_reset();

        // Pop latency
        cycle(1'b1, 1, 8'hA5, 3'b000);
        chk("lat_valid", 32'(bus_if.out_valid[1]), 32'h1);
        chk("lat_payload", 32'(bus_if.out_payload[1*DW +: DW]), 32'hA5);
        cycle(1'b0, 0, 8'h00, 3'b010);
        chk("lat_popped", 32'(bus_if.out_valid[1]), 32'h0);
        chk("lat_occ", 32'(bus_if.occupancy[1*CW +: CW]), 32'h0);

        // Reservation: q0 may take only the shared portion
        for (int i = 0; i < 6; i++) cycle(1'b1, 0, 8'(i), 3'b000);
        chk("resv_ready", 32'(bus_if.in_ready), 32'h6);
        cycle(1'b1, 1, 8'h40, 3'b000);
        cycle(1'b1, 2, 8'h50, 3'b000);
        chk("full_ready", 32'(bus_if.in_ready), 32'h0);
        chk("full_occ_sum", 32'(occ_sum()), 32'd8);
        cycle(1'b1, 0, 8'hEE, 3'b000);
        chk("full_reject", 32'(occ_sum()), 32'd8);
        for (int i = 0; i < 6; i++) cycle(1'b0, 0, 8'h00, 3'b111);

        // Concurrent pops on all queues
        for (int q = 0; q < QC; q++)
            for (int k = 0; k < 2; k++) cycle(1'b1, q, 8'(8'h10 * q + k + 1), 3'b000);
        cycle(1'b0, 0, 8'h00, 3'b111);
        chk("conc_second", 32'(bus_if.out_payload[2*DW +: DW]), 32'h22);
        cycle(1'b0, 0, 8'h00, 3'b111);
        chk("conc_empty", 32'(bus_if.out_valid), 32'h0);
        chk("conc_ready", 32'(bus_if.in_ready), 32'h7);

        // Same-queue push and pop on a one-entry queue
        cycle(1'b1, 2, 8'h11, 3'b000);
        cycle(1'b1, 2, 8'h22, 3'b100);
        chk("same_occ", 32'(bus_if.occupancy[2*CW +: CW]), 32'h1);
        chk("same_payload", 32'(bus_if.out_payload[2*DW +: DW]), 32'h22);

        // Peak occupancy
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 0, 8'(8'h60 + i), 3'b000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, 8'h00, 3'b001);
        for (int i = 0; i < 2; i++) cycle(1'b1, 0, 8'(8'h70 + i), 3'b000);
        chk("hw_q0", 32'(bus_if.high_water[0 +: CW]), exp_hw(0));
`ifdef POOLED_MULTI_QUEUE_HIGH_WATER_EN
        chk("hw_q0_val", 32'(bus_if.high_water[0 +: CW]), 32'd5);
`else
        chk("hw_off", 32'(bus_if.high_water), 32'd0);
`endif

        // Random traffic, including illegal targets and a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            logic          v;
            int            tgt;
            logic [DW-1:0] pl;
            logic [QC-1:0] rdy;
            v   = ($urandom_range(0, 9) < 8);
            tgt = int'($urandom_range(0, 3));
            pl  = 8'($urandom);
            rdy = 3'($urandom) & 3'($urandom);
            if (n == 1500) do_reset();
            cycle(v, tgt, pl, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
